// File: rtl/mac_pipe_pkg.sv
// Shared opcode set and helpers for the pipelined multiply-accumulate unit.
package mac_pipe_pkg;

    typedef enum logic [3:0] {
        MAC_REGA    = 4'h0,
        MAC_REGB    = 4'h1,
        MAC_MULT    = 4'h2,
        MAC_ACC     = 4'h3,
        MAC_MSW     = 4'h4,
        MAC_LSW     = 4'h5,
        MAC_RESET   = 4'h6,
        MAC_MACC    = 4'h7,
        MAC_GRD     = 4'h8,
        MAC_CLRFLAG = 4'h9
    } mac_op_e;

    // Ops that read or write the accumulator / registerC must wait for the pipe to drain.
    function automatic logic waits_for_pipe(input logic [3:0] op);
        case (op)
            MAC_ACC, MAC_MSW, MAC_LSW, MAC_GRD, MAC_RESET: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mac_mult_pipe.sv
// Two-stage registered multiplier: operands captured at issue, product registered
// one cycle later, with a valid bit and an accumulate tag riding alongside.
module mac_mult_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 0
) (
    input  logic                    clk,
    input  logic                    a_reset,
    input  logic                    issue_valid,
    input  logic                    issue_acc,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    res_valid,
    output logic                    res_acc,
    output logic [2*DATA_WIDTH-1:0] product
);

    logic [DATA_WIDTH-1:0]   s1_a;
    logic [DATA_WIDTH-1:0]   s1_b;
    logic                    s1_valid;
    logic                    s1_acc;
    logic [2*DATA_WIDTH-1:0] ext_a;
    logic [2*DATA_WIDTH-1:0] ext_b;
    logic [2*DATA_WIDTH-1:0] prod;

    // The low 2W bits of the product of extended operands are exact in both modes.
    always_comb begin
        if (SIGNED != 0) begin
            ext_a = {{DATA_WIDTH{s1_a[DATA_WIDTH-1]}}, s1_a};
            ext_b = {{DATA_WIDTH{s1_b[DATA_WIDTH-1]}}, s1_b};
        end else begin
            ext_a = {{DATA_WIDTH{1'b0}}, s1_a};
            ext_b = {{DATA_WIDTH{1'b0}}, s1_b};
        end
        prod = ext_a * ext_b;
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            s1_a      <= '0;
            s1_b      <= '0;
            s1_valid  <= 1'b0;
            s1_acc    <= 1'b0;
            res_valid <= 1'b0;
            res_acc   <= 1'b0;
            product   <= '0;
        end else begin
            s1_valid  <= issue_valid;
            s1_acc    <= issue_acc;
            if (issue_valid) begin
                s1_a <= op_a;
                s1_b <= op_b;
            end
            res_valid <= s1_valid;
            res_acc   <= s1_acc;
            if (s1_valid) begin
                product <= prod;
            end
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// Pipelined MAC: operand registers, registerC, guarded accumulator with sticky
// overflow and optional saturation, in-flight tracking and a registered read-back port.
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GUARD_BITS = 4,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  a_reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            opcode,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic                  acc_overflow,
    output logic                  busy
);

    localparam int PW    = 2 * DATA_WIDTH;
    localparam int ACC_W = PW + GUARD_BITS;

    logic [DATA_WIDTH-1:0] reg_a;
    logic [DATA_WIDTH-1:0] reg_b;
    logic [PW-1:0]         reg_c;
    logic [ACC_W-1:0]      acc;
    logic [1:0]            in_flight;

    logic                  accept;
    logic                  issue;
    logic                  mp_valid;
    logic                  mp_acc;
    logic [PW-1:0]         mp_product;

    logic                  add_en;
    logic [ACC_W-1:0]      addend;
    logic [ACC_W:0]        sum;
    logic                  add_ovf;
    logic [ACC_W-1:0]      acc_next;
    logic [DATA_WIDTH-1:0] grd_word;

    // Handshake: a command transfers when cmd_valid && cmd_ready at a rising edge;
    // cmd_ready looks only at opcode and in_flight, never at cmd_valid.
    assign cmd_ready = !(waits_for_pipe(opcode) && (in_flight != 2'd0));
    assign accept    = cmd_valid && cmd_ready;
    assign issue     = accept && ((opcode == MAC_MULT) || (opcode == MAC_MACC));
    assign busy      = (in_flight != 2'd0);
    assign grd_word  = DATA_WIDTH'(acc[ACC_W-1:PW]);

    function automatic logic [ACC_W-1:0] extend(input logic [PW-1:0] v);
        if (SIGNED != 0) return {{GUARD_BITS{v[PW-1]}}, v};
        else             return {{GUARD_BITS{1'b0}}, v};
    endfunction

    mac_mult_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED     (SIGNED)
    ) u_mult (
        .clk         (clk),
        .a_reset     (a_reset),
        .issue_valid (issue),
        .issue_acc   (opcode == MAC_MACC),
        .op_a        (reg_a),
        .op_b        (reg_b),
        .res_valid   (mp_valid),
        .res_acc     (mp_acc),
        .product     (mp_product)
    );

    // A retiring product and an accepted ACC never coincide: ACC waits for an empty pipe.
    always_comb begin
        add_en   = (mp_valid && mp_acc) || (accept && (opcode == MAC_ACC));
        addend   = mp_valid ? extend(mp_product) : extend(reg_c);
        sum      = {1'b0, acc} + {1'b0, addend};
        if (SIGNED != 0) begin
            add_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            add_ovf = sum[ACC_W];
        end
        acc_next = sum[ACC_W-1:0];
        if ((SATURATE != 0) && add_ovf) begin
            if (SIGNED == 0)            acc_next = '1;
            else if (addend[ACC_W-1])   acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            else                        acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            in_flight <= 2'd0;
        end else begin
            in_flight <= in_flight + {1'b0, issue} - {1'b0, mp_valid};
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            reg_c        <= '0;
            acc          <= '0;
            acc_overflow <= 1'b0;
        end else begin
            if (mp_valid) begin
                reg_c <= mp_product;
            end
            if (accept && (opcode == MAC_RESET)) begin
                acc <= '0;
            end else if (add_en) begin
                acc <= acc_next;
            end
            // A clear arriving with an overflowing retire loses: the new overflow is kept.
            if (add_en && add_ovf) begin
                acc_overflow <= 1'b1;
            end else if (accept && (opcode == MAC_CLRFLAG)) begin
                acc_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            reg_a     <= '0;
            reg_b     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                case (opcode)
                    MAC_REGA: reg_a <= data_in;
                    MAC_REGB: reg_b <= data_in;
                    MAC_MSW: begin
                        data_out  <= acc[PW-1:DATA_WIDTH];
                        out_valid <= 1'b1;
                    end
                    MAC_LSW: begin
                        data_out  <= acc[DATA_WIDTH-1:0];
                        out_valid <= 1'b1;
                    end
                    MAC_GRD: begin
                        data_out  <= grd_word;
                        out_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: three variants (unsigned wrap, unsigned saturate, signed wrap)
// share one command stream; an architectural model predicts every read-back word.
module tb_mac_pipe;
    import mac_pipe_pkg::*;

    logic       clk = 1'b0;
    logic       a_reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [7:0] data_in = 8'h00;

    logic       rdy0, rdy1, rdy2;
    logic [7:0] dout0, dout1, dout2;
    logic       ovld0, ovld1, ovld2;
    logic       ovf0, ovf1, ovf2;
    logic       bsy0, bsy1, bsy2;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [7:0]  exp_q2[$];
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [15:0] m_c[3];
    logic [19:0] m_acc[3];
    logic        m_ovf[3];

    always #5 clk = ~clk;

    mac_pipe #(.DATA_WIDTH(8), .GUARD_BITS(4), .SIGNED(0), .SATURATE(0)) u_wrap (
        .clk(clk), .a_reset(a_reset), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .opcode(opcode), .data_in(data_in), .data_out(dout0), .out_valid(ovld0),
        .acc_overflow(ovf0), .busy(bsy0));
    mac_pipe #(.DATA_WIDTH(8), .GUARD_BITS(4), .SIGNED(0), .SATURATE(1)) u_sat (
        .clk(clk), .a_reset(a_reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .opcode(opcode), .data_in(data_in), .data_out(dout1), .out_valid(ovld1),
        .acc_overflow(ovf1), .busy(bsy1));
    mac_pipe #(.DATA_WIDTH(8), .GUARD_BITS(4), .SIGNED(1), .SATURATE(0)) u_sgn (
        .clk(clk), .a_reset(a_reset), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
        .opcode(opcode), .data_in(data_in), .data_out(dout2), .out_valid(ovld2),
        .acc_overflow(ovf2), .busy(bsy2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [15:0] m_prod(input int v, input logic [7:0] a, input logic [7:0] b);
        longint p;
        if (v == 2) p = longint'($signed(a)) * longint'($signed(b));
        else        p = longint'(a) * longint'(b);
        return p[15:0];
    endfunction

    function automatic longint m_val16(input int v, input logic [15:0] x);
        if (v == 2) return longint'($signed(x));
        return longint'(x);
    endfunction

    task automatic m_add(input int v, input longint addend);
        longint cur, s, hi, lo;
        if (v == 2) begin
            cur = longint'($signed(m_acc[v])); hi = 524287;  lo = -524288;
        end else begin
            cur = longint'(m_acc[v]);          hi = 1048575; lo = 0;
        end
        s = cur + addend;
        if (s > hi || s < lo) begin
            m_ovf[v] = 1'b1;
            if (v == 1) s = (addend < 0) ? lo : hi;
        end
        m_acc[v] = s[19:0];
    endtask

    task automatic m_reset_all();
        m_a = 8'h00; m_b = 8'h00;
        for (int v = 0; v < 3; v++) begin
            m_c[v] = 16'h0; m_acc[v] = 20'h0; m_ovf[v] = 1'b0;
        end
    endtask

    task automatic m_push(input int v, input logic [7:0] w);
        if (v == 0) exp_q0.push_back(w);
        else if (v == 1) exp_q1.push_back(w);
        else exp_q2.push_back(w);
    endtask

    task automatic m_update(input logic [3:0] op, input logic [7:0] d);
        for (int v = 0; v < 3; v++) begin
            case (op)
                MAC_REGA:    if (v == 0) m_a = d;
                MAC_REGB:    if (v == 0) m_b = d;
                MAC_MULT:    m_c[v] = m_prod(v, m_a, m_b);
                MAC_MACC: begin
                    m_c[v] = m_prod(v, m_a, m_b);
                    m_add(v, m_val16(v, m_c[v]));
                end
                MAC_ACC:     m_add(v, m_val16(v, m_c[v]));
                MAC_MSW:     m_push(v, m_acc[v][15:8]);
                MAC_LSW:     m_push(v, m_acc[v][7:0]);
                MAC_GRD:     m_push(v, {4'h0, m_acc[v][19:16]});
                MAC_RESET:   m_acc[v] = 20'h0;
                MAC_CLRFLAG: m_ovf[v] = 1'b0;
                default: ;
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [3:0] op, input logic [7:0] d, output int stalls);
        logic r;
        cmd_valid = 1'b1; opcode = op; data_in = d; stalls = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); r = rdy0;
            @(posedge clk); #1;
            if (r) begin stalls = c; break; end
        end
        if (stalls < 0) check("accept_timeout", 32'd0, 32'd1);
        else m_update(op, d);
    endtask

    task automatic op(input logic [3:0] o, input logic [7:0] d);
        int s;
        issue(o, d, s);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_ovf_wrap"}, ovf0, m_ovf[0]);
        check({tag, "_ovf_sat"},  ovf1, m_ovf[1]);
        check({tag, "_ovf_sgn"},  ovf2, m_ovf[2]);
    endtask

    task automatic read_all();
        op(MAC_MSW, 8'h00); op(MAC_LSW, 8'h00); op(MAC_GRD, 8'h00);
        idle(2);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : scoreboard
        logic [7:0] e;
        if (ovld0) begin
            checks++;
            assert (exp_q0.size() != 0) else begin failures++; $error("FAIL unexp_out_wrap observed=%0h expected=none", dout0); end
            if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); check("rd_wrap", dout0, e); end
        end
        if (ovld1) begin
            checks++;
            assert (exp_q1.size() != 0) else begin failures++; $error("FAIL unexp_out_sat observed=%0h expected=none", dout1); end
            if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); check("rd_sat", dout1, e); end
        end
        if (ovld2) begin
            checks++;
            assert (exp_q2.size() != 0) else begin failures++; $error("FAIL unexp_out_sgn observed=%0h expected=none", dout2); end
            if (exp_q2.size() != 0) begin e = exp_q2.pop_front(); check("rd_sgn", dout2, e); end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        int st;
        m_reset_all();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",    rdy0, 1'b1);
        check("rst_ready_sg", rdy2, 1'b1);
        check("rst_busy",     bsy0, 1'b0);
        check("rst_dout",     dout0, 8'h00);
        check("rst_outvalid", ovld0, 1'b0);
        check_flags("rst");
        a_reset = 1'b0;
        @(posedge clk); #1;

        // MULT then dependent ACC: registerC=0x00FF, ACC waits until N+3
        op(MAC_REGA, 8'h0F); op(MAC_REGB, 8'h11); op(MAC_MULT, 8'h00);
        issue(MAC_ACC, 8'h00, st);
        check("acc_stall_cycles", st, 2);
        op(MAC_LSW, 8'h00); op(MAC_MSW, 8'h00);
        idle(2);

        // Three back-to-back MACC of 0xFF*0xFF, never stalled
        op(MAC_RESET, 8'h00); op(MAC_REGA, 8'hFF); op(MAC_REGB, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            issue(MAC_MACC, 8'h00, st);
            check("macc_no_stall", st, 0);
        end
        check("busy_two_in_flight", bsy0, 1'b1);
        read_all();
        check("busy_drained", bsy0, 1'b0);

        // MULT immediately followed by LSW
        op(MAC_REGA, 8'h03); op(MAC_REGB, 8'h05); op(MAC_MULT, 8'h00);
        opcode = MAC_LSW; cmd_valid = 1'b1; #1;
        check("hz_ready_low", rdy0, 1'b0);
        check("hz_busy_high", bsy0, 1'b1);
        issue(MAC_LSW, 8'h00, st);
        check("hz_lsw_accept_n3", st, 2);
        check("hz_busy_low", bsy0, 1'b0);
        idle(2);

        // 17 MACC of 0xFF*0xFF; CLRFLAG lands on the overflowing retire
        op(MAC_RESET, 8'h00); op(MAC_CLRFLAG, 8'h00);
        op(MAC_REGA, 8'hFF); op(MAC_REGB, 8'hFF);
        for (int i = 0; i < 17; i++) op(MAC_MACC, 8'h00);
        op(4'hF, 8'h00);
        op(MAC_CLRFLAG, 8'h00);
        m_ovf[0] = 1'b1; m_ovf[1] = 1'b1; // overflow set on the same edge wins over the clear
        idle(2);
        check_flags("ovf17");
        read_all();
        op(MAC_CLRFLAG, 8'h00);
        idle(1);
        check_flags("clr");

        // Signed -1 * 2
        op(MAC_RESET, 8'h00); op(MAC_REGA, 8'hFF); op(MAC_REGB, 8'h02); op(MAC_MACC, 8'h00);
        read_all();
        check_flags("neg");

        // Random operand accumulation with an ACC of the last product
        op(MAC_RESET, 8'h00);
        for (int i = 0; i < 6; i++) begin
            op(MAC_REGA, 8'($urandom_range(0, 255)));
            op(MAC_REGB, 8'($urandom_range(0, 255)));
            op(MAC_MACC, 8'h00);
        end
        op(MAC_ACC, 8'h00);
        read_all();
        check_flags("rand");

        // Reset one cycle after an accepted MACC discards it
        op(MAC_REGA, 8'h40); op(MAC_REGB, 8'h40); op(MAC_MACC, 8'h00);
        cmd_valid = 1'b0; a_reset = 1'b1; #1;
        check("rstmid_busy", bsy0, 1'b0);
        @(negedge clk);
        check("rstmid_outvalid", ovld0, 1'b0);
        @(posedge clk); #1;
        a_reset = 1'b0;
        m_reset_all();
        opcode = MAC_LSW; #1;
        check("rstmid_ready", rdy0, 1'b1);
        idle(3);
        read_all();
        check_flags("rstmid");

        idle(3);
        check("q_wrap_empty", exp_q0.size(), 0);
        check("q_sat_empty",  exp_q1.size(), 0);
        check("q_sgn_empty",  exp_q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised, pipelined multiply-accumulate unit that succeeds the 8-bit single-cycle MAC on the SAP-1 datapath. It is driven by the control sequencer through a valid/ready command port that carries the same 4-bit opcode stream. It adds:
- a fused multiply-accumulate opcode with single-cycle issue throughput;
- signed or unsigned arithmetic;
- accumulator guard bits with a sticky overflow flag and optional saturation;
- a qualified read-back port.

## Interface
Parameters:
- DATA_WIDTH, 8, operand and read-back word width.
- GUARD_BITS, 4, extra accumulator MSBs; ACC_W = 2*DATA_WIDTH + GUARD_BITS.
- SIGNED, 0, 1 = two's-complement operands, product and accumulator.
- SATURATE, 0, 1 = clamp the accumulator on overflow; 0 = wrap.

Ports:
- clk  in  1  single clock, rising edge.
- a_reset  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- opcode  in  4  command code; values come from the shared header.
- data_in  in  DATA_WIDTH  operand for REGA/REGB.
- data_out  out  DATA_WIDTH  read-back word, registered.
- out_valid  out  1  one-cycle pulse qualifying data_out.
- acc_overflow  out  1  sticky overflow flag.
- busy  out  1  a product is in flight.

## Operation
- REGA / REGB: load operand register A or B from data_in.
- MULT: registerC <= A*B, full 2*DATA_WIDTH product, signed per SIGNED.
- MACC: registerC <= A*B and accumulator <= accumulator + product (sign-extended when SIGNED=1).
- ACC: accumulator <= accumulator + registerC (extended to ACC_W).
- MSW / LSW / GRD: data_out <= accumulator[2W-1:W], [W-1:0], or guard bits zero-extended.
- RESET: accumulator <= 0. acc_overflow is unaffected.
- CLRFLAG: acc_overflow <= 0.
- Unknown opcode: accepted, no effect.
- Overflow definition:
  - Unsigned: carry out of ACC_W bits.
  - Signed: ACC_W-bit two's-complement overflow.
  - On overflow, acc_overflow is set and stays set until CLRFLAG or reset.
  - SATURATE=1 clamps to the maximum value (unsigned), or to the max/min matching the sign of the addend (signed). SATURATE=0 wraps.
- Hazard rule:
  - ACC, MSW, LSW, GRD and RESET stall (cmd_ready=0) while in_flight != 0.
  - REGA, REGB, MULT, MACC and CLRFLAG are never stalled.
  - cmd_ready may depend combinationally on opcode and in_flight, but never on cmd_valid.
- Simultaneous events:
  - REGA/REGB accepted while a product is in flight do not affect that product; operands are captured at issue.
  - CLRFLAG in the same cycle as an overflowing retire leaves acc_overflow set (set wins).

## Timing
- Reset: all registers, data_out, out_valid and acc_overflow are 0; in_flight is 0; cmd_ready is 1.
- Reset mid-operation discards in-flight products; no out_valid follows.
- MULT/MACC accepted at edge N updates registerC, and the accumulator for MACC, at edge N+2.
- Issue throughput is 1 per cycle; up to 2 products are in flight.
- busy = (in_flight != 0).
- A stalled dependent op held valid after a MULT at edge N is accepted at edge N+3.
- A read accepted at edge N drives data_out and out_valid=1 from edge N, for one cycle only.

## Structure
- Add MAC_MACC, MAC_GRD and MAC_CLRFLAG to sap1_header.vh. The existing MAC_* opcodes keep their values.
- One sub-module, mac_mult_pipe: a 2-stage registered multiplier carrying a valid bit and an "accumulate" tag, parametrised by DATA_WIDTH and SIGNED.
- The top level holds the operand registers, accumulator, saturation logic, in_flight counter and read-back register.

## Test plan
All cases use DATA_WIDTH=8, GUARD_BITS=4.
- REGA=0x0F, REGB=0x11, MULT, ACC, LSW, MSW -> registerC=0x00FF at N+2; LSW gives 0xFF, MSW gives 0x00, each with a single out_valid pulse.
- Three back-to-back MACC with A=B=0xFF -> cmd_ready stays high; accumulator=0x2FA03; MSW=0xFA, LSW=0x03, GRD=0x02.
- MULT at edge N followed immediately by LSW -> cmd_ready low until LSW is accepted at edge N+3; busy is high over the same window.
- 17 MACC of 0xFF*0xFF:
  - SATURATE=1 -> accumulator=0xFFFFF and acc_overflow=1.
  - SATURATE=0 -> accumulator=0x0DE11 and acc_overflow=1.
  - Then CLRFLAG -> acc_overflow=0.
- SIGNED=1, A=0xFF, B=0x02, MACC -> accumulator=0xFFFFE; MSW=0xFF, LSW=0xFE, acc_overflow=0.
- MACC accepted, a_reset asserted the next cycle -> accumulator=0 and busy=0; no out_valid; cmd_ready=1 after reset is released.
